// File: rtl/inst_fetch_unit.sv
// Sequential instruction fetch with a single outstanding imem request,
// branch redirect and a small prefetch FIFO feeding the IF/ID register.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction_IF,
    output logic [31:0] pc_IF,
    output logic        valid_IF
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

    state_t             state_reg;
    logic [31:0]        fetch_pc_reg;
    logic [31:0]        addr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [CNT_W-1:0]   count_reg;

    logic [31:0]        instr_mem [DEPTH];
    logic [31:0]        pc_mem    [DEPTH];

    logic               handshake;
    logic               push;
    logic               pop;
    logic [31:0]        next_pc;
    logic               unused_bits;

    // Low address bits of a redirect target are dropped.
    assign unused_bits = ^branch_addr[1:0];

    // In IDLE the request is gated combinationally so a redirect or reset
    // suppresses it in the same cycle; once raised it is held until accepted.
    always_comb begin
        imem_req  = 1'b1;
        imem_addr = addr_reg;
        if (state_reg == IDLE) begin
            imem_req  = (count_reg < DEPTH_C) && !branch_taken && rst;
            imem_addr = fetch_pc_reg;
        end
    end

    assign handshake = imem_req && imem_ready;
    assign push      = handshake && (state_reg != DRAIN) && !branch_taken && rst;
    assign pop       = valid_IF && !freeze && !branch_taken;
    assign next_pc   = imem_addr + 32'd4;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg    <= IDLE;
            fetch_pc_reg <= RESET_PC;
            addr_reg     <= RESET_PC;
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
            count_reg    <= '0;
        end else if (branch_taken) begin
            fetch_pc_reg <= {branch_addr[31:2], 2'b00};
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
            count_reg    <= '0;
            // An unfinished request must still complete; its data is dropped.
            case (state_reg)
                WAIT, DRAIN: state_reg <= handshake ? IDLE : DRAIN;
                default:     state_reg <= IDLE;
            endcase
        end else begin
            case (state_reg)
                IDLE: begin
                    if (imem_req && !imem_ready) begin
                        state_reg <= WAIT;
                        addr_reg  <= fetch_pc_reg;
                    end
                end
                WAIT:    if (imem_ready) state_reg <= IDLE;
                DRAIN:   if (imem_ready) state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
            if (push) begin
                fetch_pc_reg <= next_pc;
                wr_ptr_reg   <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // FIFO storage carries no reset; empty entries are masked at the output.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr_reg] <= imem_rdata;
            pc_mem[wr_ptr_reg]    <= next_pc;
        end
    end

    assign valid_IF       = (count_reg != '0);
    assign instruction_IF = valid_IF ? instr_mem[rd_ptr_reg] : 32'h0;
    assign pc_IF          = valid_IF ? pc_mem[rd_ptr_reg]    : 32'h0;
endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: memory model with programmable latency
// and a scoreboard of expected fetch addresses checked as words are consumed.
module tb_inst_fetch_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata;
    logic [31:0] instruction_IF;
    logic [31:0] pc_IF;
    logic        valid_IF;

    int n_cmp = 0;
    int n_err = 0;
    int unsigned latency  = 0;
    int unsigned wait_cnt = 0;
    int          hs_count = 0;
    logic        req_s = 1'b0;
    logic        hs_s  = 1'b0;
    logic        rst_s = 1'b0;
    logic [31:0] hs_log [$];
    logic [31:0] exp_q  [$];

    always #5 clk = ~clk;

    inst_fetch_unit #(.RESET_PC(32'h0000_0100), .DEPTH(2)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
        .branch_addr(branch_addr), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .instruction_IF(instruction_IF), .pc_IF(pc_IF), .valid_IF(valid_IF)
    );

    // Memory returns its own address as the instruction word.
    assign imem_rdata = imem_addr;

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Sample handshake and consumption away from the active edge.
    always @(negedge clk) begin
        logic [31:0] e;
        req_s = imem_req;
        hs_s  = imem_req && imem_ready;
        rst_s = rst;
        if (rst && hs_s) begin
            hs_count++;
            hs_log.push_back(imem_addr);
        end
        if (rst && valid_IF && !freeze && !branch_taken) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $error("FAIL sb_extra observed=%h expected=none", instruction_IF);
            end else begin
                e = exp_q.pop_front();
                $display("consume instr=%h pc=%h expected_addr=%h", instruction_IF, pc_IF, e);
                check32("sb_instr", instruction_IF, e);
                check32("sb_pc", pc_IF, e + 32'd4);
            end
        end
    end

    // Ready is decided shortly after each edge, once the request is stable.
    always @(posedge clk) begin
        #2;
        if (!rst_s || hs_s || !req_s) wait_cnt = 0;
        else wait_cnt++;
        imem_ready = imem_req && (wait_cnt >= latency);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 80) begin
            step();
            k++;
        end
        freeze = 1'b1;
        n_cmp++;
        assert (exp_q.size() == 0) else begin
            n_err++;
            $error("FAIL %s_timeout observed=%0d words left expected=0", tag, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        int hs0;
        rst = 1'b0; freeze = 1'b0; branch_taken = 1'b0; branch_addr = 32'h0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check32("rst_req", {31'b0, imem_req}, 32'h0);
        check32("rst_addr", imem_addr, 32'h100);
        check32("rst_instr", instruction_IF, 32'h0);
        check32("rst_pc", pc_IF, 32'h0);
        check32("rst_valid", {31'b0, valid_IF}, 32'h0);

        // Startup with zero-wait memory
        step();
        exp_q = '{32'h100, 32'h104, 32'h108, 32'h10C};
        rst = 1'b1;
        @(negedge clk);
        check32("first_req", {31'b0, imem_req}, 32'h1);
        check32("first_addr", imem_addr, 32'h100);
        drain("startup");

        // Freeze fill: only DEPTH requests while the head is held
        step(); rst = 1'b0; freeze = 1'b1;
        step(); rst = 1'b1;
        hs0 = hs_count;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i >= 1) check32("freeze_head", instruction_IF, 32'h100);
        end
        check32("freeze_reqs", 32'(hs_count - hs0), 32'd2);
        check32("freeze_req_low", {31'b0, imem_req}, 32'h0);
        exp_q = '{32'h100, 32'h104, 32'h108, 32'h10C};
        step(); freeze = 1'b0;
        drain("freeze_release");

        // Redirect while a slow request is outstanding
        step(); rst = 1'b0; latency = 3;
        step(); rst = 1'b1;
        step();
        branch_taken = 1'b1; branch_addr = 32'h0000_0403; freeze = 1'b0;
        hs_log.delete();
        exp_q = '{32'h400, 32'h404, 32'h408};
        step(); branch_taken = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check32("stale_req", {31'b0, imem_req}, 32'h1);
            check32("stale_addr", imem_addr, 32'h100);
            if (imem_ready) break;
        end
        drain("redirect_wait");
        check32("redir_hs_n", {31'b0, hs_log.size() >= 2}, 32'h1);
        if (hs_log.size() >= 2) begin
            check32("redir_hs0", hs_log[0], 32'h100);
            check32("redir_hs1", hs_log[1], 32'h400);
        end

        // Redirect coincident with a completion and a would-be pop
        step(); rst = 1'b0; latency = 1;
        step(); rst = 1'b1;
        step(); step(); step();
        branch_taken = 1'b1; branch_addr = 32'h800; freeze = 1'b0;
        @(negedge clk);
        check32("hit_pre_valid", {31'b0, valid_IF}, 32'h1);
        check32("hit_pre_hs", {31'b0, imem_req && imem_ready}, 32'h1);
        step(); branch_taken = 1'b0;
        exp_q = '{32'h800, 32'h804};
        @(negedge clk);
        check32("hit_valid", {31'b0, valid_IF}, 32'h0);
        check32("hit_instr", instruction_IF, 32'h0);
        check32("hit_pc", pc_IF, 32'h0);
        check32("hit_req", {31'b0, imem_req}, 32'h1);
        check32("hit_addr", imem_addr, 32'h800);
        drain("redirect_hit");

        // Address wrap-around
        latency = 0;
        repeat (8) step();
        branch_taken = 1'b1; branch_addr = 32'hFFFF_FFF8; freeze = 1'b0;
        hs_log.delete();
        exp_q = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0};
        step(); branch_taken = 1'b0;
        drain("wrap");
        check32("wrap_hs_n", {31'b0, hs_log.size() >= 3}, 32'h1);
        if (hs_log.size() >= 3) begin
            check32("wrap_hs0", hs_log[0], 32'hFFFF_FFF8);
            check32("wrap_hs1", hs_log[1], 32'hFFFF_FFFC);
            check32("wrap_hs2", hs_log[2], 32'h0);
        end

        // Reset while waiting with the FIFO holding a word
        latency = 4;
        repeat (8) step();
        branch_taken = 1'b1; branch_addr = 32'h200;
        step(); branch_taken = 1'b0;
        repeat (6) step();
        rst = 1'b0;
        @(negedge clk);
        check32("mid_pre_req", {31'b0, imem_req}, 32'h1);
        check32("mid_pre_valid", {31'b0, valid_IF}, 32'h1);
        step();
        @(negedge clk);
        check32("mid_req", {31'b0, imem_req}, 32'h0);
        check32("mid_valid", {31'b0, valid_IF}, 32'h0);
        check32("mid_instr", instruction_IF, 32'h0);
        check32("mid_addr", imem_addr, 32'h100);
        step();
        latency = 0; rst = 1'b1; freeze = 1'b0;
        exp_q = '{32'h100, 32'h104, 32'h108};
        @(negedge clk);
        check32("restart_req", {31'b0, imem_req}, 32'h1);
        check32("restart_addr", imem_addr, 32'h100);
        drain("restart");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
